// File: rtl/studio2_mem_arbiter_pkg.sv
// Shared types and memory-map constants for the Studio II memory arbiter.
// Imported by the address decoder and the arbiter top.
package studio2_pkg;

  typedef enum logic [1:0] {
    RegionRom,
    RegionCart,
    RegionRam,
    RegionUnmapped
  } region_e;

  typedef enum logic [1:0] {
    OwnerNone,
    OwnerCpu,
    OwnerDma
  } owner_e;

  typedef enum logic [1:0] {
    SrcRam,
    SrcRom,
    SrcFf
  } src_e;

  typedef struct packed {
    owner_e owner;
    src_e   src;
  } ret_t;

  localparam logic [11:0] CART_BASE   = 12'h400;
  localparam logic [11:0] VRAM_BASE   = 12'h900;
  localparam logic [11:0] RAM_BASE    = 12'h800;
  // Clearing bit 10 folds 0xC00-0xDFF onto 0x800-0x9FF.
  localparam logic [11:0] MIRROR_MASK = 12'hBFF;

  function automatic src_e region_src(input region_e region);
    case (region)
      RegionRom:             return SrcRom;
      RegionCart, RegionRam: return SrcRam;
      default:               return SrcFf;
    endcase
  endfunction

endpackage

// File: rtl/studio2_mem_arbiter_if.sv
// Requester and memory-side bus of the Studio II memory arbiter.
// master is the environment (CPU, DMA, download port, RAM/ROM); slave is the arbiter.
interface studio2_mem_arbiter_if;

  logic        dl_active;
  logic        dl_wr;
  logic [11:0] dl_addr;
  logic [7:0]  dl_data;

  logic        dma_req;
  logic [7:0]  dma_addr;
  logic        dma_ack;
  logic [7:0]  dma_data;
  logic        dma_valid;

  logic        cpu_rd;
  logic        cpu_wr;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_rvalid;
  logic        cpu_wait;

  logic        mem_ce;
  logic        mem_we;
  logic [11:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic [10:0] rom_addr;
  logic [7:0]  rom_rdata;

  logic        cart_present;

  modport master (
    output dl_active, dl_wr, dl_addr, dl_data,
    output dma_req, dma_addr,
    output cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
    output mem_rdata, rom_rdata,
    input  dma_ack, dma_data, dma_valid,
    input  cpu_rdata, cpu_rvalid, cpu_wait,
    input  mem_ce, mem_we, mem_addr, mem_wdata, rom_addr,
    input  cart_present
  );

  modport slave (
    input  dl_active, dl_wr, dl_addr, dl_data,
    input  dma_req, dma_addr,
    input  cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
    input  mem_rdata, rom_rdata,
    output dma_ack, dma_data, dma_valid,
    output cpu_rdata, cpu_rvalid, cpu_wait,
    output mem_ce, mem_we, mem_addr, mem_wdata, rom_addr,
    output cart_present
  );

endinterface

// File: rtl/studio2_mem_arbiter_addr_decode.sv
// Combinational Studio II console memory-map decoder for CPU addresses.
// Bits [15:12] alias; the cart window maps to RAM only when a cartridge is loaded.
module studio2_addr_decode
  import studio2_pkg::*;
(
  input  logic [15:0] addr,
  input  logic        cart_present,
  output region_e     region,
  output logic [11:0] mem_addr,
  output logic [10:0] rom_addr
);

  logic unused_high;
  assign unused_high = ^addr[15:12];

  assign rom_addr = addr[10:0];

  always_comb begin
    region   = RegionUnmapped;
    mem_addr = addr[11:0];
    // Decode on 512-byte blocks.
    case (addr[11:9])
      3'b000, 3'b001: region = RegionRom;
      3'b010, 3'b011: region = cart_present ? RegionCart : RegionRom;
      3'b100: begin
        region   = RegionRam;
        mem_addr = RAM_BASE | {3'b000, addr[8:0]};
      end
      3'b110: begin
        region   = RegionRam;
        mem_addr = addr[11:0] & MIRROR_MASK;
      end
      default: region = RegionUnmapped;
    endcase
  end

endmodule

// File: rtl/studio2_mem_arbiter.sv
// Fixed-priority (download > DMA > CPU) owner arbiter for the shared Studio II RAM/ROM,
// with a one-stage read-return pipeline and cartridge presence tracking.
module studio2_mem_arbiter
  import studio2_pkg::*;
#(
  parameter int unsigned CART_BYTES = 1024
) (
  input logic                clk,
  input logic                reset,
  studio2_mem_arbiter_if.slave bus
);

  logic        dl_active_q;
  logic [10:0] dl_cnt_q, dl_cnt_d;
  logic        cart_q, cart_d;
  ret_t        ret_q, ret_d;

  logic        dl_busy, dl_rise, dl_fall, dl_accept;
  logic        cpu_req, dma_grant, cpu_grant, cpu_ram;
  region_e     cpu_region;
  logic [11:0] cpu_mem_addr;
  logic [10:0] cpu_rom_addr;
  logic [7:0]  ret_byte;

  // The falling-edge cycle still belongs to the download so cart_present settles first.
  assign dl_busy   = bus.dl_active | dl_active_q;
  assign dl_rise   = bus.dl_active & ~dl_active_q;
  assign dl_fall   = ~bus.dl_active & dl_active_q;
  assign dl_accept = ~reset & bus.dl_active & bus.dl_wr & (32'(bus.dl_addr) < CART_BYTES);

  assign cpu_req      = bus.cpu_rd | bus.cpu_wr;
  assign dma_grant    = ~reset & bus.dma_req & ~dl_busy;
  assign cpu_grant    = ~reset & cpu_req & ~dl_busy & ~bus.dma_req;
  assign bus.cpu_wait = ~reset & cpu_req & (dl_busy | bus.dma_req);
  assign bus.dma_ack  = dma_grant;

  studio2_addr_decode u_decode (
    .addr         (bus.cpu_addr),
    .cart_present (cart_q),
    .region       (cpu_region),
    .mem_addr     (cpu_mem_addr),
    .rom_addr     (cpu_rom_addr)
  );

  assign cpu_ram      = (cpu_region == RegionRam) || (cpu_region == RegionCart);
  assign bus.rom_addr = cpu_rom_addr;

  always_comb begin
    bus.mem_ce    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = cpu_mem_addr;
    bus.mem_wdata = bus.cpu_wdata;
    ret_d         = ret_t'{owner: OwnerNone, src: SrcFf};
    if (dl_accept) begin
      bus.mem_ce    = 1'b1;
      bus.mem_we    = 1'b1;
      bus.mem_addr  = CART_BASE | {2'b00, bus.dl_addr[9:0]};
      bus.mem_wdata = bus.dl_data;
    end else if (dma_grant) begin
      bus.mem_ce   = 1'b1;
      bus.mem_addr = VRAM_BASE | {4'h0, bus.dma_addr};
      ret_d        = ret_t'{owner: OwnerDma, src: SrcRam};
    end else if (cpu_grant) begin
      bus.mem_ce = cpu_ram;
      if (bus.cpu_wr) begin
        bus.mem_we = cpu_ram;
      end else begin
        ret_d = ret_t'{owner: OwnerCpu, src: region_src(cpu_region)};
      end
    end
  end

  always_comb begin
    dl_cnt_d = dl_rise ? 11'd0 : dl_cnt_q;
    if (dl_accept && (32'(dl_cnt_d) < CART_BYTES)) begin
      dl_cnt_d = dl_cnt_d + 11'd1;
    end
    cart_d = cart_q;
    if (dl_rise) begin
      cart_d = 1'b0;
    end else if (dl_fall) begin
      cart_d = (dl_cnt_q != 11'd0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dl_active_q <= 1'b0;
      dl_cnt_q    <= 11'd0;
      cart_q      <= 1'b0;
      ret_q       <= ret_t'{owner: OwnerNone, src: SrcFf};
    end else begin
      dl_active_q <= bus.dl_active;
      dl_cnt_q    <= dl_cnt_d;
      cart_q      <= cart_d;
      ret_q       <= ret_d;
    end
  end

  always_comb begin
    case (ret_q.src)
      SrcRam:  ret_byte = bus.mem_rdata;
      SrcRom:  ret_byte = bus.rom_rdata;
      default: ret_byte = 8'hFF;
    endcase
  end

  assign bus.cpu_rvalid   = ~reset & (ret_q.owner == OwnerCpu);
  assign bus.dma_valid    = ~reset & (ret_q.owner == OwnerDma);
  assign bus.cpu_rdata    = bus.cpu_rvalid ? ret_byte : 8'h00;
  assign bus.dma_data     = bus.dma_valid ? ret_byte : 8'h00;
  assign bus.cart_present = cart_q;

endmodule

// File: tb/tb_studio2_mem_arbiter.sv
// Randomised and directed bench for studio2_mem_arbiter against a memory-map level model.
module tb_studio2_mem_arbiter;

  localparam int unsigned CART_BYTES = 1024;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  studio2_mem_arbiter_if bus ();

  studio2_mem_arbiter #(.CART_BYTES(CART_BYTES)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [7:0] rom_val(input logic [10:0] a);
    return (a[7:0] + 8'h40) ^ {5'b00000, a[10:8]};
  endfunction

  function automatic logic [7:0] ram_init(input logic [11:0] a);
    return a[7:0] ^ 8'h96 ^ {4'h0, a[11:8]};
  endfunction

  // Environment RAM/ROM devices, one-cycle read latency.
  logic [7:0] dev_ram [4096];
  bit         dev_wr  [4096];
  always @(posedge clk) begin
    if (bus.mem_ce && bus.mem_we) begin
      dev_ram[bus.mem_addr] <= bus.mem_wdata;
      dev_wr[bus.mem_addr]  <= 1'b1;
    end
    bus.mem_rdata <= dev_wr[bus.mem_addr] ? dev_ram[bus.mem_addr] : ram_init(bus.mem_addr);
    bus.rom_rdata <= rom_val(bus.rom_addr);
  end

  // Reference model state.
  logic [7:0] m_ram [4096];
  bit         m_cart, m_prev_dl, pend_cpu, pend_dma, exp_wait_last;
  int         m_cnt;
  logic [7:0] pend_cpu_data, pend_dma_data;

  // Snapshot of DUT outputs at the last sample point.
  logic        s_dma_ack, s_cpu_wait, s_cpu_rvalid, s_dma_valid, s_mem_we, s_cart;
  logic [7:0]  s_cpu_rdata, s_dma_data;
  logic [11:0] s_mem_addr;
  logic [10:0] s_rom_addr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // RAM byte a CPU address lands on, or -1 if it does not hit RAM.
  function automatic int ram_slot(input logic [15:0] a, input bit cart);
    int x;
    x = int'(a[11:0]);
    if (x >= 'h400 && x < 'h800 && cart) return x;
    if (x >= 'h800 && x < 'hA00) return x;
    if (x >= 'hC00 && x < 'hE00) return x - 'h400;
    return -1;
  endfunction

  function automatic logic [7:0] cpu_read_val(input logic [15:0] a, input bit cart);
    int slot;
    slot = ram_slot(a, cart);
    if (slot >= 0) return m_ram[slot];
    if (a[11:0] < 12'h800) return rom_val(a[10:0]);
    return 8'hFF;
  endfunction

  task automatic step();
    bit cpu_req, busy, e_ack, e_wait, accept;
    int slot;
    #1;
    cpu_req = bus.cpu_rd || bus.cpu_wr;
    busy    = bus.dl_active || m_prev_dl;
    e_ack   = !reset && bus.dma_req && !busy;
    e_wait  = !reset && cpu_req && (busy || bus.dma_req);
    accept  = !reset && cpu_req && !e_wait;

    s_dma_ack    = bus.dma_ack;
    s_cpu_wait   = bus.cpu_wait;
    s_cpu_rvalid = bus.cpu_rvalid;
    s_cpu_rdata  = bus.cpu_rdata;
    s_dma_valid  = bus.dma_valid;
    s_dma_data   = bus.dma_data;
    s_mem_addr   = bus.mem_addr;
    s_mem_we     = bus.mem_we;
    s_rom_addr   = bus.rom_addr;
    s_cart       = bus.cart_present;

    check("dma_ack", 32'(bus.dma_ack), 32'(e_ack));
    check("cpu_wait", 32'(bus.cpu_wait), 32'(e_wait));
    check("cpu_rvalid", 32'(bus.cpu_rvalid), 32'(pend_cpu && !reset));
    if (pend_cpu && !reset) check("cpu_rdata", 32'(bus.cpu_rdata), 32'(pend_cpu_data));
    check("dma_valid", 32'(bus.dma_valid), 32'(pend_dma && !reset));
    if (pend_dma && !reset) check("dma_data", 32'(bus.dma_data), 32'(pend_dma_data));
    check("cart_present", 32'(bus.cart_present), 32'(m_cart));
    if (reset) begin
      check("reset_mem_ce", 32'(bus.mem_ce), 32'd0);
      check("reset_mem_we", 32'(bus.mem_we), 32'd0);
      check("reset_cpu_rdata", 32'(bus.cpu_rdata), 32'd0);
      check("reset_dma_data", 32'(bus.dma_data), 32'd0);
    end
    exp_wait_last = e_wait;

    if (reset) begin
      m_prev_dl = 1'b0;
      m_cnt     = 0;
      m_cart    = 1'b0;
      pend_cpu  = 1'b0;
      pend_dma  = 1'b0;
    end else begin
      pend_dma = e_ack;
      if (e_ack) pend_dma_data = m_ram['h900 + int'(bus.dma_addr)];
      pend_cpu = accept && !bus.cpu_wr;
      if (pend_cpu) pend_cpu_data = cpu_read_val(bus.cpu_addr, m_cart);
      if (bus.dl_active && !m_prev_dl) begin
        m_cnt  = 0;
        m_cart = 1'b0;
      end
      if (bus.dl_active && bus.dl_wr && int'(bus.dl_addr) < CART_BYTES) begin
        m_ram['h400 + int'(bus.dl_addr) % 1024] = bus.dl_data;
        if (m_cnt < CART_BYTES) m_cnt++;
      end
      if (accept && bus.cpu_wr) begin
        slot = ram_slot(bus.cpu_addr, m_cart);
        if (slot >= 0) m_ram[slot] = bus.cpu_wdata;
      end
      if (!bus.dl_active && m_prev_dl) m_cart = (m_cnt > 0);
      m_prev_dl = bus.dl_active;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    bus.dl_active = 1'b0;
    bus.dl_wr     = 1'b0;
    bus.dl_addr   = 12'h000;
    bus.dl_data   = 8'h00;
    bus.dma_req   = 1'b0;
    bus.dma_addr  = 8'h00;
    bus.cpu_rd    = 1'b0;
    bus.cpu_wr    = 1'b0;
    bus.cpu_addr  = 16'h0000;
    bus.cpu_wdata = 8'h00;
  endtask

  task automatic cpu_op(input bit rd, input bit wr, input logic [15:0] a, input logic [7:0] d);
    bus.cpu_rd    = rd;
    bus.cpu_wr    = wr;
    bus.cpu_addr  = a;
    bus.cpu_wdata = d;
  endtask

  task automatic dl_byte(input logic [11:0] a, input logic [7:0] d);
    bus.dl_wr   = 1'b1;
    bus.dl_addr = a;
    bus.dl_data = d;
  endtask

  bit dl_on;
  int waits, k, bad;
  logic [7:0] dv;

  initial begin
    reset = 1'b1;
    idle();
    for (int i = 0; i < 4096; i++) m_ram[i] = ram_init(12'(i));
    m_cart = 0; m_prev_dl = 0; m_cnt = 0; pend_cpu = 0; pend_dma = 0; exp_wait_last = 0;
    @(posedge clk);
    @(negedge clk);
    step();
    step();
    reset = 1'b0;
    step();

    // No cart: ROM read, then unmapped read.
    cpu_op(1, 0, 16'h0405, 8'h00);
    step();
    check("rom_addr_0405", 32'(s_rom_addr), 32'h405);
    cpu_op(1, 0, 16'h0A10, 8'h00);
    step();
    check("rvalid_0405", 32'(s_cpu_rvalid), 32'd1);
    check("rdata_0405", 32'(s_cpu_rdata), 32'h41);
    idle();
    step();
    check("rdata_unmapped", 32'(s_cpu_rdata), 32'hFF);

    // Download with only an out-of-range byte; CPU held throughout.
    waits = 0;
    bus.dl_active = 1'b1;
    cpu_op(1, 0, 16'h0800, 8'h00);
    step(); waits += int'(s_cpu_wait);
    dl_byte(12'h400, 8'hEE);
    step(); waits += int'(s_cpu_wait);
    bus.dl_wr = 1'b0;
    bus.dl_active = 1'b0;
    step(); waits += int'(s_cpu_wait);
    step(); waits += int'(s_cpu_wait);
    check("dl_wait_cycles", 32'(waits), 32'd3);
    idle();
    step();
    check("cart_after_dropped", 32'(s_cart), 32'd0);
    cpu_op(1, 0, 16'h0400, 8'h00);
    step();
    idle();
    step();
    check("rdata_0400_nocart", 32'(s_cpu_rdata), 32'h44);

    // 16-byte cartridge image.
    bus.dl_active = 1'b1;
    for (int i = 0; i < 16; i++) begin
      dl_byte(12'(i), 8'(8'h10 + i));
      step();
    end
    idle();
    step();
    step();
    check("cart_after_dl", 32'(s_cart), 32'd1);
    cpu_op(1, 0, 16'h0400, 8'h00);
    step();
    cpu_op(1, 0, 16'h040F, 8'h00);
    step();
    check("rdata_0400_cart", 32'(s_cpu_rdata), 32'h10);
    idle();
    step();
    check("rdata_040f_cart", 32'(s_cpu_rdata), 32'h1F);

    // Mirror write, direct read.
    cpu_op(0, 1, 16'h0C05, 8'h5A);
    step();
    check("mirror_wr_addr", 32'(s_mem_addr), 32'h805);
    check("mirror_wr_we", 32'(s_mem_we), 32'd1);
    cpu_op(1, 0, 16'h0805, 8'h00);
    step();
    check("direct_rd_addr", 32'(s_mem_addr), 32'h805);
    idle();
    step();
    check("rdata_0805", 32'(s_cpu_rdata), 32'h5A);

    // DMA beats CPU in the same cycle; CPU follows.
    bus.dma_req  = 1'b1;
    bus.dma_addr = 8'h05;
    cpu_op(1, 0, 16'h1805, 8'h00);
    step();
    check("dma_ack_conflict", 32'(s_dma_ack), 32'd1);
    check("cpu_wait_conflict", 32'(s_cpu_wait), 32'd1);
    check("dma_mem_addr", 32'(s_mem_addr), 32'h905);
    bus.dma_req = 1'b0;
    step();
    check("dma_valid_next", 32'(s_dma_valid), 32'd1);
    check("dma_data_0905", 32'(s_dma_data), 32'h9A);
    check("cpu_granted_after", 32'(s_cpu_wait), 32'd0);
    idle();
    step();
    check("rdata_alias_1805", 32'(s_cpu_rdata), 32'h5A);

    // DMA request in the dl_active falling cycle is granted one cycle later.
    bus.dl_active = 1'b1;
    step();
    bus.dl_active = 1'b0;
    bus.dma_req   = 1'b1;
    step();
    check("dma_ack_on_fall", 32'(s_dma_ack), 32'd0);
    step();
    check("dma_ack_after_fall", 32'(s_dma_ack), 32'd1);
    idle();
    step();

    // Reset mid-download with count 5; release dl_active with reset.
    bus.dl_active = 1'b1;
    for (int i = 0; i < 5; i++) begin
      dl_byte(12'(i + 32), 8'(i));
      step();
    end
    bus.dl_wr = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus.dl_active = 1'b0;
    step();
    step();
    check("cart_after_reset_dl", 32'(s_cart), 32'd0);

    // Read in flight when reset asserts.
    cpu_op(1, 0, 16'h0805, 8'h00);
    step();
    idle();
    reset = 1'b1;
    step();
    check("rvalid_in_reset", 32'(s_cpu_rvalid), 32'd0);
    reset = 1'b0;
    step();
    check("rvalid_after_reset", 32'(s_cpu_rvalid), 32'd0);

    // Random traffic.
    dl_on = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 199) == 0);
      if (dl_on) dl_on = ($urandom_range(0, 9) != 0);
      else dl_on = ($urandom_range(0, 29) == 0);
      bus.dl_active = dl_on;
      bus.dl_wr     = dl_on ? ($urandom_range(0, 9) < 6) : ($urandom_range(0, 9) == 0);
      bus.dl_addr   = ($urandom_range(0, 3) == 0) ? 12'($urandom_range(1000, 1100))
                                                  : 12'($urandom_range(0, 63));
      bus.dl_data   = 8'($urandom);
      bus.dma_req   = ($urandom_range(0, 9) < 3);
      bus.dma_addr  = 8'($urandom);
      if (!exp_wait_last) begin
        if ($urandom_range(0, 9) < 6) begin
          k = int'($urandom_range(0, 2));
          cpu_op(k != 1, k != 0, 16'($urandom), 8'($urandom));
        end else begin
          cpu_op(0, 0, 16'h0000, 8'h00);
        end
      end
      step();
    end
    reset = 1'b0;
    idle();
    step();
    step();

    bad = 0;
    for (int i = 0; i < 4096; i++) begin
      dv = dev_wr[i] ? dev_ram[i] : ram_init(12'(i));
      if (dv !== m_ram[i]) bad++;
    end
    check("ram_contents_mismatches", 32'(bad), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/studio2_mem_arbiter.md
# studio2_mem_arbiter

Single-owner arbiter and address decoder for the Studio II memory subsystem. Sits between the CDP1802 bus, the 1861 display DMA fetch and the cartridge download port on one side, and the shared 4 KiB RAM array and 2 KiB system ROM on the other. It serialises all accesses with fixed priority, decodes the console memory map, routes read data back to the owning requester and tracks cartridge presence.

## Interface
Parameters:
- `CART_BYTES`, default 1024: maximum cartridge image size; download bytes at offset ≥ CART_BYTES are dropped.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `dl_active` in 1: cartridge download in progress.
- `dl_wr` in 1: download byte strobe.
- `dl_addr` in 12: byte offset in image.
- `dl_data` in 8: download byte.
- `dma_req` in 1: 1861 requests a display byte.
- `dma_addr` in 8: offset within display page 0x900.
- `dma_ack` out 1: DMA request granted this cycle.
- `dma_data` out 8: display byte.
- `dma_valid` out 1: dma_data valid.
- `cpu_rd` in 1: CPU read request.
- `cpu_wr` in 1: CPU write request.
- `cpu_addr` in 16: CPU address.
- `cpu_wdata` in 8: CPU write data.
- `cpu_rdata` out 8: CPU read data.
- `cpu_rvalid` out 1: cpu_rdata valid.
- `cpu_wait` out 1: CPU request not accepted this cycle; hold it.
- `mem_ce` out 1: RAM enable.
- `mem_we` out 1: RAM write enable.
- `mem_addr` out 12: RAM address.
- `mem_wdata` out 8: RAM write data.
- `mem_rdata` in 8: RAM read data, 1-cycle latency.
- `rom_addr` out 11: system ROM address.
- `rom_rdata` in 8: ROM data, 1-cycle latency.
- `cart_present` out 1: valid cartridge image loaded.

## Operation
- Decode uses `cpu_addr[11:0]`; `[15:12]` ignored (aliases). Regions:
  - 0x000–0x3FF → ROM.
  - 0x400–0x7FF → RAM (cart image) if `cart_present`, else ROM (built-in games).
  - 0x800–0x9FF → RAM.
  - 0xC00–0xDFF → RAM mirror of 0x800–0x9FF (`mem_addr[10]` cleared).
  - 0xA00–0xBFF and 0xE00–0xFFF → unmapped: reads return 0xFF, writes dropped.
- ROM writes are dropped but still accepted (no wait).
- Priority per cycle: download > DMA > CPU. Fixed priority, no rotation.
- Download: while `dl_active`, `cpu_wait`=1 for any CPU request and `dma_ack`=0. Each `dl_wr` with `dl_addr` < CART_BYTES writes RAM at 0x400+`dl_addr[9:0]`.
- Download byte counter (11 bits, saturating at CART_BYTES):
  - Cleared and `cart_present` cleared on the rising edge of `dl_active`.
  - Counts accepted writes.
  - On the falling edge of `dl_active`, `cart_present` is set iff count > 0.
- DMA: when granted, reads RAM at 0x900+`dma_addr`. `dma_ack` is high in the grant cycle. A DMA grant blocks the CPU (`cpu_wait`=1) that cycle.
- CPU: accepted when no higher-priority owner is active. A read records its source (RAM/ROM/FF) and owner in the return-pipeline register.
- Return pipeline is one stage: {owner NONE/CPU/DMA, source}. The next cycle presents `cpu_rdata`/`cpu_rvalid` or `dma_data`/`dma_valid` from `mem_rdata`, `rom_rdata` or 0xFF.
- Simultaneous `cpu_rd` and `cpu_wr`: treated as a write.

## Timing
- Fully pipelined: one access issued per cycle.
- Read data valid exactly 1 cycle after the grant cycle.
- Writes complete in the grant cycle.
- `cpu_wait` is combinational from the current requests and state, so the CPU holds address and strobes until `cpu_wait`=0.
- Reset values:
  - `dma_ack`, `dma_valid`, `cpu_rvalid`, `cpu_wait`, `mem_ce`, `mem_we` = 0.
  - `cpu_rdata`, `dma_data` = 0x00.
  - `cart_present` = 0; counter = 0; return pipeline owner = NONE.
- Reset mid-download: counter cleared, `cart_present`=0. No edge is detected until `dl_active` rises again after reset.
- A read in flight when reset asserts is discarded; no valid is produced.
- `dl_active` falling in the same cycle as `dma_req`: DMA is granted in the following cycle, not the same one.

## Structure
- Package `studio2_pkg`:
  - region enum: ROM, CART, RAM, UNMAPPED.
  - owner enum: NONE, CPU, DMA.
  - constants: CART_BASE=0x400, VRAM_BASE=0x900, RAM_BASE=0x800, mirror mask.
- Sub-module `studio2_addr_decode`, combinational: takes address and `cart_present`, returns region, `mem_addr` and `rom_addr`.

## Test plan
- No cart, CPU reads 0x0405 → `rom_addr`=0x405, `cpu_rvalid` next cycle with `rom_rdata`. Read of 0x0A10 → 0xFF.
- Download 16 bytes at offsets 0–15, then drop `dl_active` → RAM 0x400–0x40F written, `cart_present`=1. CPU read 0x0400 now comes from RAM.
- CPU write 0xC05←0x5A, then read 0x805 → returns 0x5A; `mem_addr`=0x805 for both accesses.
- `dma_req` and `cpu_rd` in the same cycle → `dma_ack`=1 and `cpu_wait`=1. `dma_valid` follows next cycle; the CPU read is granted the cycle after.
- CPU request during `dl_active` → `cpu_wait` held for the whole download. Write at `dl_addr`=0x400 is dropped and not counted.
- Reset asserted with a CPU read in flight and the download count at 5 → no `cpu_rvalid`; `cart_present`=0 after reset.
